// File: rtl/csa_sum_accumulator.sv
// ---------------------------------------------------------------------------
// csa_sum_accumulator
//
// Purpose:
//   Consumes the 6-bit {cout,sum} results of the 4-operand carry-save adder
//   over a valid/ready handshake. It adds COUNT results per batch into an
//   ACC_W-bit total, which wraps modulo 2**ACC_W. The total is then presented
//   on an output valid/ready port, together with a sticky overflow flag that
//   records any carry out of the accumulator during the batch.
//
// Parameters:
//   IN_W   width of the incoming CSA result (default 6)
//   COUNT  results accumulated per batch, 1..255 (default 4)
//   ACC_W  accumulator width (default 8)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      one-cycle pulse that begins a batch
//   in_valid   in_data is valid
//   in_ready   block accepts in_data this cycle (decoded from state)
//   in_data    CSA result {cout,sum}
//   out_valid  acc_out holds a completed batch total
//   out_ready  sink accepts acc_out
//   acc_out    batch total
//   frame_cnt  results accepted in the current batch
//   overflow   sticky carry out of ACC_W within this batch
//   busy       high while accumulating or holding (decoded from state)
// ---------------------------------------------------------------------------
module csa_sum_accumulator #(
  parameter int IN_W  = 6,
  parameter int COUNT = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [7:0]       frame_cnt,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Value frame_cnt holds when the transfer that completes the batch arrives.
  localparam logic [7:0] LAST_CNT = 8'(COUNT - 1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  // One bit wider than the accumulator so that the top bit is the carry out.
  logic [ACC_W:0]   in_ext;
  logic [ACC_W:0]   sum_ext;
  logic             xfer;

  assign in_ext  = (ACC_W + 1)'(in_data);
  assign sum_ext = {1'b0, acc_q} + in_ext;
  assign xfer    = in_valid && (state_q == ACCUM);

  // Next-state logic. Every register holds by default, so acc_out, overflow
  // and frame_cnt stay stable in HOLD and keep their last value in IDLE
  // until the next start clears them.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end

      ACCUM: begin
        // start is deliberately ignored here; only a transfer advances.
        if (xfer) begin
          acc_d = sum_ext[ACC_W-1:0];
          ovf_d = ovf_q | sum_ext[ACC_W];
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == LAST_CNT) begin
            state_d     = HOLD;
            out_valid_d = 1'b1;
          end
        end
      end

      HOLD: begin
        // start only counts when the sink takes the total in the same cycle,
        // which lets a new batch begin without an idle bubble.
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (start) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any partial batch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign acc_out   = acc_q;
  assign frame_cnt = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_csa_sum_accumulator.sv
// ---------------------------------------------------------------------------
// tb_csa_sum_accumulator
//
// Drives two accumulators from the same inputs: one with the default 8-bit
// accumulator and one narrowed to 6 bits, so that wrap-around and the sticky
// overflow flag are reachable. A batch-level reference model keeps the plain
// integer sum of the accepted results. Both totals and both overflow flags
// are then derived from that sum arithmetically.
// ---------------------------------------------------------------------------
module tb_csa_sum_accumulator;

  localparam int COUNT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [5:0] in_data = '0;
  logic       out_ready = 1'b0;

  logic       in_ready8, out_valid8, overflow8, busy8;
  logic [7:0] acc_out8, frame_cnt8;
  logic       in_ready6, out_valid6, overflow6, busy6;
  logic [5:0] acc_out6;
  logic [7:0] frame_cnt6;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = idle, 1 = accumulating, 2 = holding a total.
  int m_mode = 0;
  int m_sum  = 0;
  int m_cnt  = 0;

  csa_sum_accumulator #(.IN_W(6), .COUNT(COUNT), .ACC_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready8), .in_data(in_data), .out_valid(out_valid8),
    .out_ready(out_ready), .acc_out(acc_out8), .frame_cnt(frame_cnt8),
    .overflow(overflow8), .busy(busy8)
  );

  csa_sum_accumulator #(.IN_W(6), .COUNT(COUNT), .ACC_W(6)) u_dut6 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready6), .in_data(in_data), .out_valid(out_valid6),
    .out_ready(out_ready), .acc_out(acc_out6), .frame_cnt(frame_cnt6),
    .overflow(overflow6), .busy(busy6)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Advance the model by one clock using the inputs present at that edge.
  task automatic modelStep();
    if (rst) begin
      m_mode = 0; m_sum = 0; m_cnt = 0;
    end else begin
      case (m_mode)
        0: if (start) begin m_mode = 1; m_sum = 0; m_cnt = 0; end
        1: if (in_valid) begin
             m_sum += int'(in_data);
             m_cnt++;
             if (m_cnt == COUNT) m_mode = 2;
           end
        default: if (out_ready) begin
             if (start) begin m_mode = 1; m_sum = 0; m_cnt = 0; end
             else m_mode = 0;
           end
      endcase
    end
  endtask

  task automatic compareAll();
    checkOutput("in_ready8",  32'(in_ready8),  32'(m_mode == 1));
    checkOutput("busy8",      32'(busy8),      32'(m_mode != 0));
    checkOutput("out_valid8", 32'(out_valid8), 32'(m_mode == 2));
    checkOutput("acc_out8",   32'(acc_out8),   32'(m_sum % 256));
    checkOutput("overflow8",  32'(overflow8),  32'(m_sum >= 256));
    checkOutput("frame_cnt8", 32'(frame_cnt8), 32'(m_cnt));
    checkOutput("in_ready6",  32'(in_ready6),  32'(m_mode == 1));
    checkOutput("busy6",      32'(busy6),      32'(m_mode != 0));
    checkOutput("out_valid6", 32'(out_valid6), 32'(m_mode == 2));
    checkOutput("acc_out6",   32'(acc_out6),   32'(m_sum % 64));
    checkOutput("overflow6",  32'(overflow6),  32'(m_sum >= 64));
    checkOutput("frame_cnt6", 32'(frame_cnt6), 32'(m_cnt));
  endtask

  // Apply one cycle of inputs, clock it, then check both DUTs 1ns later.
  task automatic applyStimulus(input logic r, input logic s, input logic v,
                               input logic [5:0] d, input logic o);
    rst = r; start = s; in_valid = v; in_data = d; out_ready = o;
    @(posedge clk);
    modelStep();
    #1;
    compareAll();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 6'd0, 0);
  endtask

  initial begin
    logic [5:0] batch2 [4];
    batch2 = '{6'd10, 6'd20, 6'd22, 6'd24};

    // Reset held for two cycles.
    applyStimulus(1, 0, 0, 6'd0, 0);
    applyStimulus(1, 0, 0, 6'd0, 0);
    checkOutput("rst_acc", 32'(acc_out8), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready8), 32'd0);

    // Basic batch.
    applyStimulus(0, 1, 0, 6'd0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, batch2[i], 0);
    checkOutput("basic_valid", 32'(out_valid8), 32'd1);
    checkOutput("basic_acc", 32'(acc_out8), 32'd76);
    checkOutput("basic_cnt", 32'(frame_cnt8), 32'd4);
    checkOutput("basic_ovf", 32'(overflow8), 32'd0);
    applyStimulus(0, 0, 0, 6'd0, 1);
    checkOutput("basic_idle_busy", 32'(busy8), 32'd0);
    checkOutput("idle_hold_acc", 32'(acc_out8), 32'd76);

    // Gaps and backpressure.
    applyStimulus(0, 1, 0, 6'd0, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, 6'd60, 0);
      if (i < 3) idleCycles(2);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 6'd0, 0);
      checkOutput("bp_acc", 32'(acc_out8), 32'd240);
      checkOutput("bp_valid", 32'(out_valid8), 32'd1);
    end
    applyStimulus(0, 0, 0, 6'd0, 1);
    checkOutput("bp_release", 32'(out_valid8), 32'd0);

    // Overflow on the 6-bit accumulator; the next start clears it.
    applyStimulus(0, 1, 0, 6'd0, 0);
    applyStimulus(0, 0, 1, 6'd60, 0);
    applyStimulus(0, 0, 1, 6'd60, 0);
    applyStimulus(0, 0, 1, 6'd0, 0);
    applyStimulus(0, 0, 1, 6'd0, 0);
    checkOutput("ovf6_acc", 32'(acc_out6), 32'd56);
    checkOutput("ovf6_flag", 32'(overflow6), 32'd1);
    applyStimulus(0, 0, 0, 6'd0, 1);
    applyStimulus(0, 1, 0, 6'd0, 0);
    checkOutput("ovf6_cleared", 32'(overflow6), 32'd0);

    // Reset mid-batch, then a fresh batch.
    applyStimulus(0, 0, 1, 6'd10, 0);
    applyStimulus(0, 0, 1, 6'd20, 0);
    applyStimulus(1, 0, 0, 6'd0, 0);
    checkOutput("midrst_acc", 32'(acc_out8), 32'd0);
    checkOutput("midrst_cnt", 32'(frame_cnt8), 32'd0);
    applyStimulus(0, 1, 0, 6'd0, 0);
    for (int i = 1; i <= 4; i++) applyStimulus(0, 0, 1, 6'(i), 0);
    checkOutput("midrst_total", 32'(acc_out8), 32'd10);

    // Start together with out_ready in HOLD goes straight back to ACCUM.
    applyStimulus(0, 1, 0, 6'd0, 1);
    checkOutput("hold_start_rdy", 32'(in_ready8), 32'd1);
    checkOutput("hold_start_acc", 32'(acc_out8), 32'd0);
    checkOutput("hold_start_cnt", 32'(frame_cnt8), 32'd0);
    applyStimulus(0, 1, 1, 6'd5, 0);
    checkOutput("accum_start_cnt", 32'(frame_cnt8), 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 6'd7, 0);
    checkOutput("accum_start_acc", 32'(acc_out8), 32'd26);
    // start without out_ready in HOLD is ignored.
    applyStimulus(0, 1, 0, 6'd0, 0);
    checkOutput("hold_start_ign", 32'(out_valid8), 32'd1);
    applyStimulus(0, 0, 0, 6'd0, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 9) < 6),
                    6'($urandom_range(0, 63)),
                    ($urandom_range(0, 1) == 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
